nios2_mul_share_ctrl: RTL and testbench

- Shares one pipelined 32x32->64 multiplier cell between NUM_REQ requesters, e.g. the CPU custom-instruction path and a DSP accelerator.
- Round-robin arbitration on valid/ready request ports.
- Drives the cell's operand, sign, input-enable (ena0) and output-enable (ena1) pins.
- Tracks requester ownership through the cell's 2-stage pipeline and returns each 64-bit product to its owner, with backpressure.

---
 rtl/nios2_mul_share_ctrl.sv | 100 ++++++++++
 tb/tb_nios2_mul_share_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/nios2_mul_share_ctrl.sv
// nios2_mul_share_ctrl: round-robin sharing of one 2-stage pipelined 32x32->64 multiplier cell
module nios2_mul_share_ctrl #(
  parameter int NUM_REQ = 2,
  parameter int CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*32-1:0] req_src1,
  input  logic [NUM_REQ*32-1:0] req_src2,
  input  logic [NUM_REQ-1:0]    req_src1_signed,
  input  logic [NUM_REQ-1:0]    req_src2_signed,
  output logic [NUM_REQ-1:0]    rsp_valid,
  input  logic [NUM_REQ-1:0]    rsp_ready,
  output logic [63:0]           rsp_result,
  output logic [31:0]           mul_src1,
  output logic [31:0]           mul_src2,
  output logic                  mul_src1_signed,
  output logic                  mul_src2_signed,
  output logic                  mul_in_en,
  output logic                  mul_out_en,
  input  logic [63:0]           mul_result,
  output logic                  idle,
  output logic [CNT_W-1:0]      issue_count
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic            r_v1, r_v2;
  logic [ID_W-1:0] r_id1, r_id2, r_rr;
  logic [CNT_W-1:0] r_cnt;
  logic            w_out_adv, w_in_adv, w_found, w_acc;
  logic [ID_W-1:0] w_win, w_idx;

  assign w_out_adv  = ~r_v2 | rsp_ready[r_id2];
  assign w_in_adv   = ~r_v1 | w_out_adv;
  assign w_acc      = w_found & w_in_adv & reset_n;
  assign mul_out_en = w_out_adv;
  assign mul_in_en  = w_in_adv;
  assign req_ready  = {NUM_REQ{w_acc}} & (NUM_REQ'(1) << w_win);
  assign rsp_valid  = NUM_REQ'(r_v2) << r_id2;
  assign rsp_result = mul_result;
  assign idle       = ~r_v1 & ~r_v2;
  assign issue_count = r_cnt;

  // first valid requester at or after the rr pointer; descending scan so the nearest wins
  always_comb begin
    w_found = 1'b0;
    w_win   = r_rr;
    w_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_idx = ID_W'((int'(r_rr) + k) % NUM_REQ);
      if (req_valid[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  // operand/sign mux from the winner (rr pointer requester when nobody is valid)
  always_comb begin
    mul_src1        = '0;
    mul_src2        = '0;
    mul_src1_signed = 1'b0;
    mul_src2_signed = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_win == ID_W'(i)) begin
        mul_src1        = req_src1[32*i +: 32];
        mul_src2        = req_src2[32*i +: 32];
        mul_src1_signed = req_src1_signed[i];
        mul_src2_signed = req_src2_signed[i];
      end
    end
  end

  // ownership tracking through both cell stages, rr pointer and issue counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_v1  <= 1'b0;
      r_v2  <= 1'b0;
      r_id1 <= '0;
      r_id2 <= '0;
      r_rr  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_in_adv) begin
        r_v1 <= w_acc;
        if (w_acc) r_id1 <= w_win;
      end
      if (w_out_adv) begin
        r_v2  <= r_v1;
        r_id2 <= r_id1;
      end
      if (w_acc) begin
        r_rr  <= (w_win == ID_W'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_nios2_mul_share_ctrl.sv
// tb_nios2_mul_share_ctrl: directed scoreboard bench with a behavioural multiplier cell
module tb_nios2_mul_share_ctrl;
  localparam int NR = 2;
  localparam int CW = 4;

  typedef struct {int id; logic [63:0] p;} item_t;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [NR-1:0]   req_valid = '0, req_ready, req_s1s = '0, req_s2s = '0;
  logic [NR*32-1:0] req_src1 = '0, req_src2 = '0;
  logic [NR-1:0]   rsp_valid, rsp_ready = '0;
  logic [63:0]     rsp_result, mul_result;
  logic [31:0]     mul_src1, mul_src2;
  logic            mul_s1s, mul_s2s, mul_in_en, mul_out_en, idle;
  logic [CW-1:0]   issue_count;

  logic [31:0] c_a, c_b;
  logic        c_sa, c_sb;
  logic signed [65:0] c_pr;
  logic [63:0] c_res;

  item_t sb[$];
  int total = 0, bad = 0, exp_cnt = 0;
  logic [63:0] held;

  nios2_mul_share_ctrl #(.NUM_REQ(NR), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_src1(req_src1), .req_src2(req_src2), .req_src1_signed(req_s1s), .req_src2_signed(req_s2s),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .mul_src1(mul_src1), .mul_src2(mul_src2), .mul_src1_signed(mul_s1s), .mul_src2_signed(mul_s2s),
    .mul_in_en(mul_in_en), .mul_out_en(mul_out_en), .mul_result(mul_result),
    .idle(idle), .issue_count(issue_count)
  );

  always #5 clk = ~clk;

  // two-stage cell: ena0-gated operand/sign registers, ena1-gated product register, aclr
  always_comb c_pr = $signed({c_sa & c_a[31], c_a}) * $signed({c_sb & c_b[31], c_b});
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      c_a <= '0; c_b <= '0; c_sa <= 1'b0; c_sb <= 1'b0; c_res <= '0;
    end else begin
      if (mul_in_en) begin
        c_a <= mul_src1; c_b <= mul_src2; c_sa <= mul_s1s; c_sb <= mul_s2s;
      end
      if (mul_out_en) c_res <= c_pr[63:0];
    end
  end
  assign mul_result = c_res;

  task automatic chk(input string t, input logic [63:0] o, input logic [63:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", t, o, e);
    end
  endtask

  // pops the scoreboard on every response handshake
  always @(negedge clk) begin
    if (reset_n && (rsp_valid & rsp_ready) != '0) begin
      if (sb.size() == 0) chk("stray_rsp", 64'(rsp_valid), 64'(0));
      else begin
        item_t e;
        e = sb.pop_front();
        chk("rsp_owner", 64'(rsp_valid), 64'(1) << e.id);
        chk("rsp_result", rsp_result, e.p);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int i, input logic [31:0] a, input logic [31:0] b,
                      input logic sa, input logic sb_s, input logic [63:0] exp);
    int n = 0;
    req_valid = '0;
    req_valid[i] = 1'b1;
    req_src1[32*i +: 32] = a;
    req_src2[32*i +: 32] = b;
    req_s1s[i] = sa;
    req_s2s[i] = sb_s;
    sb.push_back('{i, exp});
    exp_cnt++;
    @(negedge clk);
    while (!req_ready[i] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("grant", 64'(req_ready[i]), 64'(1));
    tick();
    req_valid = '0;
  endtask

  task automatic drain;
    int n = 0;
    while ((sb.size() != 0 || !idle) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 64'(sb.size() == 0 && idle), 64'(1));
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog");
    $fatal(1, "timeout");
  end

  initial begin
    req_valid = 2'b11;
    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(req_ready), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_idle", 64'(idle), 64'(1));
    chk("rst_count", 64'(issue_count), 64'(0));
    req_valid = '0;
    tick();
    reset_n = 1'b1;
    rsp_ready = 2'b11;
    tick();
    send(0, 32'hFFFFFFFD, 32'd5, 1'b1, 1'b1, 64'hFFFFFFFFFFFFFFF1);
    @(negedge clk);
    chk("lat_not_yet", 64'(rsp_valid), 64'(0));
    chk("count_1", 64'(issue_count), 64'(1));
    chk("busy", 64'(idle), 64'(0));
    tick();
    @(negedge clk);
    chk("lat_valid", 64'(rsp_valid), 64'(1));
    tick();
    @(negedge clk);
    chk("idle_after", 64'(idle), 64'(1));
    tick();
    send(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 64'hFFFFFFFE00000001);
    send(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 64'h0000000000000001);
    drain();
    req_src1 = {32'h00010000, 32'd7};
    req_src2 = {32'h00010000, 32'd6};
    req_s1s = '0;
    req_s2s = '0;
    req_valid = 2'b11;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("fair_grant", 64'(req_ready), (c % 2) ? 64'(2) : 64'(1));
      sb.push_back('{c % 2, (c % 2) ? 64'h100000000 : 64'd42});
      exp_cnt++;
      tick();
    end
    req_valid = '0;
    drain();
    chk("count_fair", 64'(issue_count), 64'(exp_cnt % 16));
    rsp_ready = '0;
    send(0, 32'd2, 32'd3, 1'b0, 1'b0, 64'd6);
    send(0, 32'd4, 32'd5, 1'b0, 1'b0, 64'd20);
    req_valid = 2'b01;
    req_src1[31:0] = 32'd9;
    req_src2[31:0] = 32'd9;
    @(negedge clk);
    chk("bp_stall", 64'(req_ready), 64'(0));
    chk("bp_valid", 64'(rsp_valid), 64'(1));
    chk("bp_result", rsp_result, 64'd6);
    held = rsp_result;
    tick();
    @(negedge clk);
    chk("bp_stall2", 64'(req_ready), 64'(0));
    chk("bp_stable", rsp_result, held);
    tick();
    rsp_ready = 2'b01;
    @(negedge clk);
    chk("bp_release", 64'(req_ready), 64'(1));
    sb.push_back('{0, 64'd81});
    exp_cnt++;
    tick();
    req_valid = '0;
    drain();
    rsp_ready = '0;
    send(0, 32'd1, 32'd1, 1'b0, 1'b0, 64'd1);
    send(0, 32'd2, 32'd2, 1'b0, 1'b0, 64'd4);
    chk("mid_busy", 64'(idle), 64'(0));
    reset_n = 1'b0;
    #1;
    chk("mid_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("mid_idle", 64'(idle), 64'(1));
    chk("mid_count", 64'(issue_count), 64'(0));
    sb.delete();
    exp_cnt = 0;
    rsp_ready = 2'b11;
    tick();
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("no_stale", 64'(rsp_valid), 64'(0));
    end
    tick();
    send(0, 32'd7, 32'd6, 1'b0, 1'b0, 64'd42);
    drain();
    for (int i = 1; i <= 16; i++) send(0, 32'(i), 32'd3, 1'b0, 1'b0, 64'(i * 3));
    drain();
    chk("wrap", 64'(issue_count), 64'(1));
    chk("sb_empty", 64'(sb.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
